// File: rtl/n_any_gate_pkg.sv
// Shared types for the packet-level any-gate: reduction selector and FSM states.
package n_any_gate_pkg;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_XOR  = 2'b01,
    SEL_XNOR = 2'b10,
    SEL_OR   = 2'b11
  } gate_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    HOLD = 2'b10
  } state_e;

  // XNOR folds as XOR; the inversion is applied once when the result is presented.
  function automatic logic fold_bit(gate_sel_e sel, logic and_r, logic or_r, logic xor_r);
    case (sel)
      SEL_AND: fold_bit = and_r;
      SEL_OR:  fold_bit = or_r;
      default: fold_bit = xor_r;
    endcase
  endfunction

endpackage

// File: rtl/n_any_gate_reduce.sv
// Per-beat reductions of one N-bit word; purely combinational.
module n_any_gate_reduce #(
  parameter int N = 8
) (
  input  logic [N-1:0] gate_in,
  output logic         and_r,
  output logic         or_r,
  output logic         xor_r
);

  assign and_r = &gate_in;
  assign or_r  = |gate_in;
  assign xor_r = ^gate_in;

endmodule

// File: rtl/n_any_gate_stream.sv
// Streaming any-gate: folds a packet of N-bit beats into one registered result.
// Optional popcount output enabled by N_ANY_GATE_STREAM_POPCOUNT_EN.
//   state | meaning
//   IDLE  | no packet in progress, ready for a first beat
//   ACC   | packet open, folding further beats into acc
//   HOLD  | result presented, waiting for out_ready
module n_any_gate_stream
  import n_any_gate_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MAX_BEATS = 16,
  localparam int BW        = $clog2(MAX_BEATS + 1)
`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
  ,
  localparam int OW        = $clog2(N * MAX_BEATS + 1)
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  gate_in,
  input  logic [1:0]    gate_select,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          gate_out,
  output logic [BW-1:0] out_beats,
  output logic          out_overflow
`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
  ,
  output logic [OW-1:0] out_ones
`endif
);

  state_e        state;
  gate_sel_e     sel_q;
  gate_sel_e     beat_sel;
  logic          acc;
  logic          acc_nxt;
  logic          beat_bit;
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_nxt;
  logic          first;
  logic          accept;
  logic          close;
  logic          and_r;
  logic          or_r;
  logic          xor_r;

  n_any_gate_reduce #(.N(N)) u_reduce (
    .gate_in (gate_in),
    .and_r   (and_r),
    .or_r    (or_r),
    .xor_r   (xor_r)
  );

  // In HOLD a beat can only enter when the held result retires the same cycle.
  assign in_ready = rst ? 1'b0 : ((state == HOLD) ? out_ready : 1'b1);
  assign accept   = in_valid & in_ready;
  assign first    = (state != ACC);

  always_comb begin
    beat_sel = first ? gate_sel_e'(gate_select) : sel_q;
    beat_bit = fold_bit(beat_sel, and_r, or_r, xor_r);
    acc_nxt  = beat_bit;
    if (!first) begin
      case (beat_sel)
        SEL_AND: acc_nxt = acc & beat_bit;
        SEL_OR:  acc_nxt = acc | beat_bit;
        default: acc_nxt = acc ^ beat_bit;
      endcase
    end
    cnt_nxt = first ? BW'(1) : cnt + BW'(1);
    close   = in_last | (cnt_nxt == BW'(MAX_BEATS));
  end

`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
  logic [OW-1:0] ones;
  logic [OW-1:0] beat_ones;
  logic [OW-1:0] ones_nxt;

  always_comb begin
    beat_ones = '0;
    for (int i = 0; i < N; i++) begin
      beat_ones = beat_ones + OW'(gate_in[i]);
    end
    ones_nxt = (first ? '0 : ones) + beat_ones;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= SEL_AND;
      acc          <= 1'b0;
      cnt          <= '0;
      out_valid    <= 1'b0;
      gate_out     <= 1'b0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
    end else if (accept) begin
      sel_q <= beat_sel;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (close) begin
        state        <= HOLD;
        out_valid    <= 1'b1;
        gate_out     <= (beat_sel == SEL_XNOR) ? ~acc_nxt : acc_nxt;
        out_beats    <= cnt_nxt;
        out_overflow <= ~in_last;
      end else begin
        state     <= ACC;
        out_valid <= 1'b0;
      end
    end else if ((state == HOLD) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ones     <= '0;
      out_ones <= '0;
    end else if (accept) begin
      ones <= ones_nxt;
      if (close) begin
        out_ones <= ones_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_n_any_gate_stream.sv
// Bench for n_any_gate_stream (N=8, MAX_BEATS=4): vector table plus hand-written corner sequences.
module tb_n_any_gate_stream;

  localparam int N  = 8;
  localparam int MB = 4;
  localparam int BW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  gate_in = '0;
  logic [1:0]    gate_select = 2'b00;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          gate_out;
  logic [BW-1:0] out_beats;
  logic          out_overflow;
`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
  logic [$clog2(N*MB+1)-1:0] out_ones;
`endif

  n_any_gate_stream #(.N(N), .MAX_BEATS(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .gate_in      (gate_in),
    .gate_select  (gate_select),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .gate_out     (gate_out),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
`ifdef N_ANY_GATE_STREAM_POPCOUNT_EN
    ,
    .out_ones     (out_ones)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          g;
    logic [BW-1:0] b;
    logic          o;
  } exp_t;

  typedef struct {
    logic [1:0]    sel;
    logic [N-1:0]  data;
    logic          last;
    logic          close;
    exp_t          e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   results  = 0;

  function automatic exp_t mke(logic g, int b, logic o);
    exp_t e;
    e.g = g;
    e.b = BW'(b);
    e.o = o;
    return e;
  endfunction

  function automatic vec_t mkv(logic [1:0] sel, logic [N-1:0] data, logic last, logic close,
                               logic g, int b, logic o);
    vec_t v;
    v.sel   = sel;
    v.data  = data;
    v.last  = last;
    v.close = close;
    v.e     = mke(g, b, o);
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Drive one beat; push the expected result once a closing beat is accepted.
  task automatic send(input logic [1:0] sel, input logic [N-1:0] data, input logic last,
                      input logic close, input exp_t e);
    int budget;
    @(negedge clk);
    gate_select = sel;
    gate_in     = data;
    in_last     = last;
    in_valid    = 1'b1;
    #1;
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout actual in_ready=%0b expected=1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (close) sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scoreboard: every output transfer pops and compares one expected result.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result actual g=%0b beats=%0d ovf=%0b expected none",
                 gate_out, out_beats, out_overflow);
      end else begin
        e = sb.pop_front();
        results++;
        if (gate_out !== e.g || out_beats !== e.b || out_overflow !== e.o) begin
          failures++;
          $display("FAIL result%0d actual g=%0b beats=%0d ovf=%0b expected g=%0b beats=%0d ovf=%0b",
                   results, gate_out, out_beats, out_overflow, e.g, e.b, e.o);
        end
      end
    end
  end

  initial begin
    // single-beat AND, XOR / XNOR / mid-packet select change, OR, overflow
    vecs.push_back(mkv(2'b00, 8'hFF, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(2'b01, 8'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'h03, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'h00, 1, 1, 1, 3, 0));
    vecs.push_back(mkv(2'b10, 8'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 8'h03, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b10, 8'h00, 1, 1, 0, 3, 0));
    vecs.push_back(mkv(2'b01, 8'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 8'h03, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 8'h00, 1, 1, 1, 3, 0));
    vecs.push_back(mkv(2'b11, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 8'h00, 1, 1, 0, 2, 0));
    vecs.push_back(mkv(2'b11, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b11, 8'h10, 1, 1, 1, 2, 0));
    vecs.push_back(mkv(2'b00, 8'hFF, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 8'hFF, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 8'hFF, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 8'hFF, 0, 1, 1, 4, 1));
    vecs.push_back(mkv(2'b00, 8'hFF, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(2'b00, 8'hFF, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b00, 8'hFE, 1, 1, 0, 2, 0));
    vecs.push_back(mkv(2'b10, 8'h03, 1, 1, 1, 1, 0));
    vecs.push_back(mkv(2'b01, 8'h01, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(2'b01, 8'h00, 1, 1, 1, 4, 0));

    @(negedge clk);
    #1;
    check("in_ready_in_reset", 8'(in_ready), 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 8'(out_valid), 8'd0);
    check("reset_gate_out", 8'(gate_out), 8'd0);
    check("reset_out_beats", 8'(out_beats), 8'd0);
    check("reset_out_overflow", 8'(out_overflow), 8'd0);
    check("idle_in_ready", 8'(in_ready), 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].close, vecs[i].e);
    end
    idle();
    repeat (3) @(negedge clk);

    // Back-pressure: result held while out_ready is low, then retire + accept together.
    out_ready = 1'b0;
    send(2'b00, 8'hFE, 1, 1, mke(0, 1, 0));
    @(negedge clk);
    gate_select = 2'b11;
    gate_in     = 8'h0F;
    in_last     = 1'b1;
    in_valid    = 1'b1;
    #1;
    check("bp_latency_valid", 8'(out_valid), 8'd1);
    for (int c = 0; c < 3; c++) begin
      check("bp_in_ready_low", 8'(in_ready), 8'd0);
      check("bp_valid_stable", 8'(out_valid), 8'd1);
      check("bp_gate_stable", 8'(gate_out), 8'd0);
      check("bp_beats_stable", 8'(out_beats), 8'd1);
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 8'(in_ready), 8'd1);
    @(posedge clk);
    sb.push_back(mke(1, 1, 0));
    idle();
    #1;
    check("bp_next_valid", 8'(out_valid), 8'd1);
    check("bp_next_gate", 8'(gate_out), 8'd1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a packet discards the partial fold.
    send(2'b01, 8'h01, 0, 0, mke(0, 0, 0));
    send(2'b01, 8'h03, 0, 0, mke(0, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_reset_in_ready", 8'(in_ready), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_reset_out_valid", 8'(out_valid), 8'd0);
    check("mid_reset_gate_out", 8'(gate_out), 8'd0);
    check("mid_reset_out_beats", 8'(out_beats), 8'd0);
    check("mid_reset_overflow", 8'(out_overflow), 8'd0);
    send(2'b00, 8'h00, 1, 1, mke(0, 1, 0));
    idle();
    repeat (4) @(negedge clk);

    check("scoreboard_empty", 8'(sb.size()), 8'd0);
    check("result_count", 8'(results), 8'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
